holy_dbg_mem_bridge: RTL

//  AXI4 slave that sequences xbar master port 0 (0x000-0x80F) onto the dm_top debug-memory device bus.

---
 rtl/holy_dbg_bridge_pkg.sv | 23 ++
 rtl/holy_dbg_mem_bridge_if.sv | 67 ++++++
 rtl/holy_dbg_mem_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/holy_dbg_bridge_pkg.sv
// Shared types and constants for the debug-memory AXI4 bridge.
package holy_dbg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int WORD_BYTES = 4;
    // AxSIZE encoding of a full 32-bit word
    localparam logic [2:0] WORD_SIZE = 3'd2;

endpackage

// File: rtl/holy_dbg_mem_bridge_if.sv
// AXI4 slave-side channel bundle between the crossbar port and the debug-memory bridge.
interface holy_dbg_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     s_awid;
    logic [ADDR_W-1:0]   s_awaddr;
    logic [7:0]          s_awlen;
    logic [2:0]          s_awsize;
    logic [1:0]          s_awburst;
    logic                s_awvalid;
    logic                s_awready;

    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wlast;
    logic                s_wvalid;
    logic                s_wready;

    logic [ID_W-1:0]     s_bid;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;

    logic [ID_W-1:0]     s_arid;
    logic [ADDR_W-1:0]   s_araddr;
    logic [7:0]          s_arlen;
    logic [2:0]          s_arsize;
    logic [1:0]          s_arburst;
    logic                s_arvalid;
    logic                s_arready;

    logic [ID_W-1:0]     s_rid;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic                s_rvalid;
    logic                s_rready;

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        output s_arready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        input  s_arready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );

endinterface

// File: rtl/holy_dbg_mem_bridge.sv
// AXI4 slave serialising single-word accesses onto the dm_top debug-memory bus.
// Define HOLY_DBG_BRIDGE_RANGE_CHECK_EN to suppress device accesses at or above DEV_SIZE.
module holy_dbg_mem_bridge
    import holy_dbg_bridge_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              ID_W     = 4,
    parameter logic [ADDR_W-1:0] DEV_SIZE = ADDR_W'(32'h810)
) (
    input  logic                clk,
    input  logic                rst_n,
    holy_dbg_mem_bridge_if.slave s_axi,
    output logic                dev_req_o,
    output logic                dev_we_o,
    output logic [ADDR_W-1:0]   dev_addr_o,
    output logic [DATA_W/8-1:0] dev_be_o,
    output logic [DATA_W-1:0]   dev_wdata_o,
    input  logic [DATA_W-1:0]   dev_rdata_i
);

`ifdef HOLY_DBG_BRIDGE_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_t            state_reg, state_next;
    logic              rr_last_wr_reg, rr_last_wr_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        len_reg, len_next;
    logic [1:0]        burst_reg, burst_next;
    logic [7:0]        beat_cnt_reg, beat_cnt_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              fresh_reg, fresh_next;
    logic              rd_oor_reg, rd_oor_next;

    logic              last_beat;
    logic              beat_oor;
    logic              grant_rd, grant_wr;
    logic [ADDR_W-1:0] addr_step;

    assign last_beat = (beat_cnt_reg == len_reg);
    assign beat_oor  = RANGE_CHECK && (addr_reg >= DEV_SIZE);
    // WRAP bursts are deliberately stepped like INCR
    assign addr_step = (burst_reg == BURST_FIXED) ? addr_reg
                                                  : addr_reg + ADDR_W'(WORD_BYTES);

    // Round-robin: on a tie, grant the type that did not win last time
    assign grant_rd = s_axi.s_arvalid && (!s_axi.s_awvalid || rr_last_wr_reg);
    assign grant_wr = s_axi.s_awvalid && (!s_axi.s_arvalid || !rr_last_wr_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_last_wr_reg <= 1'b1;
            id_reg         <= '0;
            addr_reg       <= '0;
            len_reg        <= '0;
            burst_reg      <= '0;
            beat_cnt_reg   <= '0;
            err_reg        <= 1'b0;
            rdata_reg      <= '0;
            fresh_reg      <= 1'b0;
            rd_oor_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_last_wr_reg <= rr_last_wr_next;
            id_reg         <= id_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            burst_reg      <= burst_next;
            beat_cnt_reg   <= beat_cnt_next;
            err_reg        <= err_next;
            rdata_reg      <= rdata_next;
            fresh_reg      <= fresh_next;
            rd_oor_reg     <= rd_oor_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_last_wr_next = rr_last_wr_reg;
        id_next         = id_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        burst_next      = burst_reg;
        beat_cnt_next   = beat_cnt_reg;
        err_next        = err_reg;
        rdata_next      = rdata_reg;
        fresh_next      = fresh_reg;
        rd_oor_next     = rd_oor_reg;

        s_axi.s_awready = 1'b0;
        s_axi.s_arready = 1'b0;
        s_axi.s_wready  = 1'b0;
        s_axi.s_bvalid  = 1'b0;
        s_axi.s_bid     = id_reg;
        s_axi.s_bresp   = err_reg ? RESP_SLVERR : RESP_OKAY;
        s_axi.s_rvalid  = 1'b0;
        s_axi.s_rid     = id_reg;
        s_axi.s_rdata   = '0;
        s_axi.s_rresp   = (err_reg || rd_oor_reg) ? RESP_SLVERR : RESP_OKAY;
        s_axi.s_rlast   = last_beat;

        dev_req_o   = 1'b0;
        dev_we_o    = 1'b0;
        dev_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
        dev_be_o    = '1;
        dev_wdata_o = s_axi.s_wdata;

        unique case (state_reg)
            IDLE: begin
                s_axi.s_arready = grant_rd;
                s_axi.s_awready = grant_wr;
                beat_cnt_next   = '0;
                if (grant_rd) begin
                    id_next         = s_axi.s_arid;
                    addr_next       = s_axi.s_araddr;
                    len_next        = s_axi.s_arlen;
                    burst_next      = s_axi.s_arburst;
                    err_next        = (s_axi.s_arsize != WORD_SIZE);
                    rr_last_wr_next = 1'b0;
                    state_next      = RD_REQ;
                end else if (grant_wr) begin
                    id_next         = s_axi.s_awid;
                    addr_next       = s_axi.s_awaddr;
                    len_next        = s_axi.s_awlen;
                    burst_next      = s_axi.s_awburst;
                    err_next        = (s_axi.s_awsize != WORD_SIZE);
                    rr_last_wr_next = 1'b1;
                    state_next      = WR_DATA;
                end
            end
            RD_REQ: begin
                dev_req_o   = !beat_oor;
                rd_oor_next = beat_oor;
                fresh_next  = 1'b1;
                state_next  = RD_RESP;
            end
            RD_RESP: begin
                // First cycle forwards the device data directly, later cycles replay the capture
                s_axi.s_rvalid = 1'b1;
                if (!rd_oor_reg)
                    s_axi.s_rdata = fresh_reg ? dev_rdata_i : rdata_reg;
                if (fresh_reg)
                    rdata_next = dev_rdata_i;
                fresh_next = 1'b0;
                if (s_axi.s_rready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 8'd1;
                        addr_next     = addr_step;
                        state_next    = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                s_axi.s_wready = 1'b1;
                if (s_axi.s_wvalid) begin
                    dev_req_o = !beat_oor;
                    dev_we_o  = 1'b1;
                    dev_be_o  = s_axi.s_wstrb;
                    // The burst always ends on the count; a wlast disagreement only flags the response
                    err_next  = err_reg || beat_oor || (s_axi.s_wlast != last_beat);
                    if (last_beat) begin
                        state_next = WR_RESP;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 8'd1;
                        addr_next     = addr_step;
                    end
                end
            end
            WR_RESP: begin
                s_axi.s_bvalid = 1'b1;
                if (s_axi.s_bready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
